aprsc_tone_detect: RTL and testbench

Tone and transition detector for the multichannel ADPCM co-processor, directly downstream of APRSC. It consumes APRSC's A2P output together with DQ and the quantizer scale factor YL, and produces TDP (tone detected) and TR (transition detected) for one channel per request. TR feeds back into APRSC's TR register for that channel's next sample. It is a Wishbone slave with a REQ/ACK handshake and holds 32 channels of delayed-tone state.

---
 rtl/aprsc_tone_detect.sv | 179 +++++++++++++++++
 tb/tb_aprsc_tone_detect.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aprsc_tone_detect.sv
// Tone/transition detector downstream of APRSC: Wishbone slave with a REQ/ACK
// handshake, computing TDP and TR per request and holding per-channel TD state.
module aprsc_tone_detect #(
    parameter int CHANNELS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_wb_adr,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_dat,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic        o_wb_ack,
    output logic        o_wb_err
);

    localparam logic [7:0] ADR_DQ    = 8'h00;
    localparam logic [7:0] ADR_YL    = 8'h04;
    localparam logic [7:0] ADR_A2P   = 8'h08;
    localparam logic [7:0] ADR_CHAN  = 8'h0C;
    localparam logic [7:0] ADR_REQ   = 8'h10;
    localparam logic [7:0] ADR_ACK   = 8'h14;
    localparam logic [7:0] ADR_TR    = 8'h18;
    localparam logic [7:0] ADR_TDP   = 8'h1C;
    localparam logic [7:0] ADR_STATE = 8'h20;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC1 = 3'd1,
        CALC2 = 3'd2,
        CMP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [14:0]         dq;
    logic [18:0]         yl;
    logic [15:0]         a2p;
    logic [4:0]          chan;
    logic                req;
    logic                ack;
    logic                tr;
    logic                tdp;
    logic [CHANNELS-1:0] td_state;

    logic [13:0] dq_mag;
    logic [3:0]  yl_int;
    logic [4:0]  yl_frac;
    logic        tdp_next;
    logic        td_old;
    logic [14:0] dq_thr;
    logic        tr_next;

    logic        access;
    logic        wr;
    logic [7:0]  adr;
    logic [31:0] rd_data;
    logic        unused_bits;

    // Second strobe cycle is swallowed while ack is high: one ack per two cycles.
    assign access      = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign wr          = access & i_wb_we;
    assign adr         = i_wb_adr[7:0];
    assign o_wb_err    = 1'b0;
    assign unused_bits = ^{i_wb_sel, i_wb_adr[31:8], i_wb_dat[31:19]};

    function automatic logic [14:0] dq_threshold(input logic [3:0] yint, input logic [4:0] yfrac);
        logic [15:0] thr1;
        logic [15:0] thr2;
        logic [15:0] sum;
        thr1 = (16'd32 + {11'd0, yfrac}) << yint;
        thr2 = (yint > 4'd9) ? 16'd31744 : thr1;
        sum  = thr2 + (thr2 >> 1);
        return sum[15:1];
    endfunction

    always_comb begin
        rd_data = 32'd0;
        case (adr)
            ADR_DQ:    rd_data = {17'd0, dq};
            ADR_YL:    rd_data = {13'd0, yl};
            ADR_A2P:   rd_data = {16'd0, a2p};
            ADR_CHAN:  rd_data = {27'd0, chan};
            ADR_REQ:   rd_data = {31'd0, req};
            ADR_ACK:   rd_data = {31'd0, ack};
            ADR_TR:    rd_data = {31'd0, tr};
            ADR_TDP:   rd_data = {31'd0, tdp};
            ADR_STATE: rd_data = 32'(td_state);
            default:   rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_wb_ack <= 1'b0;
            o_wb_dat <= 32'd0;
            dq       <= '0;
            yl       <= '0;
            a2p      <= '0;
            chan     <= '0;
            req      <= 1'b0;
        end else begin
            o_wb_ack <= access;
            if (access)
                o_wb_dat <= rd_data;
            // Operand registers are frozen while a computation is in flight.
            if (wr && state == IDLE) begin
                case (adr)
                    ADR_DQ:   dq   <= i_wb_dat[14:0];
                    ADR_YL:   yl   <= i_wb_dat[18:0];
                    ADR_A2P:  a2p  <= i_wb_dat[15:0];
                    ADR_CHAN: chan <= i_wb_dat[4:0];
                    default:  ;
                endcase
            end
            if (wr && adr == ADR_REQ)
                req <= i_wb_dat[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = CALC1;
            CALC1:   state_next = CALC2;
            CALC2:   state_next = CMP;
            CMP:     state_next = DONE;
            DONE:    if (!req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign tr_next = ({1'b0, dq_mag} > dq_thr) & td_old;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dq_mag   <= '0;
            yl_int   <= '0;
            yl_frac  <= '0;
            tdp_next <= 1'b0;
            td_old   <= 1'b0;
            dq_thr   <= '0;
            tr       <= 1'b0;
            tdp      <= 1'b0;
            ack      <= 1'b0;
            td_state <= '0;
        end else begin
            case (state)
                CALC1: begin
                    dq_mag   <= dq[13:0];
                    yl_int   <= yl[18:15];
                    yl_frac  <= yl[14:10];
                    tdp_next <= a2p[15] & (a2p < 16'hD200);
                    td_old   <= td_state[chan];
                end
                CALC2: dq_thr <= dq_threshold(yl_int, yl_frac);
                CMP: begin
                    tr             <= tr_next;
                    tdp            <= tdp_next;
                    td_state[chan] <= tr_next ? 1'b0 : tdp_next;
                    ack            <= 1'b1;
                end
                DONE: if (!req) ack <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aprsc_tone_detect.sv
// Bench for aprsc_tone_detect: directed vector table, randomized requests against
// an arithmetic reference model, and hand-written handshake/reset sequences.
module tb_aprsc_tone_detect;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        err;

    int compared   = 0;
    int mismatched = 0;
    bit model_td[32];

    always #5 clk = ~clk;

    aprsc_tone_detect #(.CHANNELS(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_wb_adr (adr),
        .i_wb_sel (sel),
        .i_wb_we  (we),
        .i_wb_dat (wdat),
        .o_wb_dat (rdat),
        .i_wb_cyc (cyc),
        .i_wb_stb (stb),
        .o_wb_ack (ack),
        .o_wb_err (err)
    );

    typedef struct {
        logic [4:0]  chan;
        logic [15:0] a2p;
        logic [18:0] yl;
        logic [14:0] dq;
        logic        tr;
        logic        tdp;
        logic [31:0] state;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wb_access(input logic [7:0] a, input logic w, input logic [31:0] d,
                             output logic [31:0] q);
        int n;
        adr  = {24'd0, a};
        we   = w;
        wdat = d;
        cyc  = 1'b1;
        stb  = 1'b1;
        n    = 0;
        q    = 32'd0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack && n < 8);
        if (!ack) begin
            compared++;
            mismatched++;
            $display("FAIL wb_ack_timeout: got no ack at 0x%0h, expected ack within 8 cycles", a);
        end else begin
            q = rdat;
        end
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_access(a, 1'b1, d, dummy);
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [31:0] q);
        wb_access(a, 1'b0, 32'd0, q);
    endtask

    task automatic poll_ack(input logic want, input string name);
        logic [31:0] q;
        int n;
        n = 0;
        do begin
            wb_read(8'h14, q);
            n++;
        end while (q[0] !== want && n < 20);
        if (q[0] !== want) begin
            compared++;
            mismatched++;
            $display("FAIL %s: ACK stayed %0d, expected %0d within 20 polls", name, q[0], want);
        end
    endtask

    task automatic load_operands(input logic [4:0] ch, input logic [15:0] a, input logic [18:0] y,
                                 input logic [14:0] d);
        wb_write(8'h00, {17'd0, d});
        wb_write(8'h04, {13'd0, y});
        wb_write(8'h08, {16'd0, a});
        wb_write(8'h0C, {27'd0, ch});
    endtask

    task automatic do_req(input logic [4:0] ch, input logic [15:0] a, input logic [18:0] y,
                          input logic [14:0] d, output logic rtr, output logic rtdp,
                          output logic [31:0] rstate);
        logic [31:0] q;
        load_operands(ch, a, y, d);
        wb_write(8'h10, 32'd1);
        poll_ack(1'b1, "ack_set");
        wb_read(8'h18, q);
        rtr = q[0];
        wb_read(8'h1C, q);
        rtdp = q[0];
        wb_read(8'h20, rstate);
        wb_write(8'h10, 32'd0);
        poll_ack(1'b0, "ack_clear");
    endtask

    function automatic int model_dqthr(input logic [18:0] y);
        int yint;
        int frac;
        int thr;
        yint = int'(y[18:15]);
        frac = int'(y[14:10]);
        if (yint > 9)
            thr = 31 * 1024;
        else
            thr = (32 + frac) * (1 << yint);
        return (thr + thr / 2) / 2;
    endfunction

    function automatic void model_req(input int ch, input logic [15:0] a, input logic [18:0] y,
                                      input logic [14:0] d, output logic etr, output logic etdp,
                                      output logic [31:0] estate);
        int  sa;
        bit  tone;
        int  mag;
        sa   = int'($signed(a));
        tone = (sa < -11776);
        mag  = int'(d[13:0]);
        etr  = (mag > model_dqthr(y)) && model_td[ch];
        etdp = tone;
        model_td[ch] = etr ? 1'b0 : tone;
        estate = 32'd0;
        for (int i = 0; i < 32; i++)
            if (model_td[i]) estate |= (32'd1 << i);
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q;
        logic [31:0] rstate;
        logic [31:0] estate;
        logic        rtr, rtdp, etr, etdp;
        logic [4:0]  ch;
        logic [15:0] a;
        logic [18:0] y;
        logic [14:0] d;
        int          thr;
        int          mag;
        logic [31:0] lat[3];

        vecs[0]  = '{5'd3,  16'hC000, 19'h00000, 15'h3FFF, 1'b0, 1'b1, 32'h0000_0008};
        vecs[1]  = '{5'd3,  16'h0000, 19'h00000, 15'h0019, 1'b1, 1'b0, 32'h0000_0000};
        vecs[2]  = '{5'd3,  16'hC000, 19'h00000, 15'h3FFF, 1'b0, 1'b1, 32'h0000_0008};
        vecs[3]  = '{5'd3,  16'h0000, 19'h00000, 15'h0018, 1'b0, 1'b0, 32'h0000_0000};
        vecs[4]  = '{5'd10, 16'hD1FF, 19'h00000, 15'h0000, 1'b0, 1'b1, 32'h0000_0400};
        vecs[5]  = '{5'd11, 16'hD200, 19'h00000, 15'h0000, 1'b0, 1'b0, 32'h0000_0400};
        vecs[6]  = '{5'd12, 16'h7FFF, 19'h00000, 15'h0000, 1'b0, 1'b0, 32'h0000_0400};
        vecs[7]  = '{5'd13, 16'h8000, 19'h00000, 15'h0000, 1'b0, 1'b1, 32'h0000_2400};
        vecs[8]  = '{5'd7,  16'hC000, 19'h00000, 15'h0000, 1'b0, 1'b1, 32'h0000_2480};
        vecs[9]  = '{5'd7,  16'h0000, 19'h4A000, 15'h3C01, 1'b1, 1'b0, 32'h0000_2400};
        vecs[10] = '{5'd7,  16'hC000, 19'h00000, 15'h0000, 1'b0, 1'b1, 32'h0000_2480};
        vecs[11] = '{5'd7,  16'h0000, 19'h4A000, 15'h3C00, 1'b0, 1'b0, 32'h0000_2400};
        vecs[12] = '{5'd7,  16'hC000, 19'h00000, 15'h0000, 1'b0, 1'b1, 32'h0000_2480};
        vecs[13] = '{5'd7,  16'h0000, 19'h50000, 15'h3FFF, 1'b0, 1'b0, 32'h0000_2400};
        vecs[14] = '{5'd0,  16'hC000, 19'h00000, 15'h0000, 1'b0, 1'b1, 32'h0000_2401};
        vecs[15] = '{5'd31, 16'hC000, 19'h00000, 15'h0000, 1'b0, 1'b1, 32'h8000_2401};
        vecs[16] = '{5'd5,  16'h0000, 19'h00000, 15'h0000, 1'b0, 1'b0, 32'h8000_2401};

        reset = 1'b0;
        adr   = 32'd0;
        sel   = 4'hF;
        we    = 1'b0;
        wdat  = 32'd0;
        cyc   = 1'b0;
        stb   = 1'b0;
        for (int i = 0; i < 32; i++) model_td[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_wb_ack", {31'd0, ack}, 32'd0);
        check("reset_wb_dat", rdat, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        wb_read(8'h20, q);
        check("init_state", q, 32'd0);
        wb_read(8'h14, q);
        check("init_ack", q, 32'd0);

        for (int i = 0; i < 17; i++) begin
            do_req(vecs[i].chan, vecs[i].a2p, vecs[i].yl, vecs[i].dq, rtr, rtdp, rstate);
            model_req(int'(vecs[i].chan), vecs[i].a2p, vecs[i].yl, vecs[i].dq, etr, etdp, estate);
            check($sformatf("vec%0d_tr", i), {31'd0, rtr}, {31'd0, vecs[i].tr});
            check($sformatf("vec%0d_tdp", i), {31'd0, rtdp}, {31'd0, vecs[i].tdp});
            check($sformatf("vec%0d_state", i), rstate, vecs[i].state);
        end

        // ACK latency: reads sampled at 2,4,6 and at 3,5,7 cycles after REQ lands.
        load_operands(5'd20, 16'h0000, 19'h0, 15'h0);
        wb_write(8'h10, 32'd1);
        for (int k = 0; k < 3; k++) wb_read(8'h14, lat[k]);
        check("lat_a_e2", lat[0], 32'd0);
        check("lat_a_e4", lat[1], 32'd0);
        check("lat_a_e6", lat[2], 32'd1);
        wb_write(8'h10, 32'd0);
        wb_read(8'h14, q);
        check("ack_clear_2cyc", q, 32'd0);
        model_req(20, 16'h0000, 19'h0, 15'h0, etr, etdp, estate);

        wb_write(8'h10, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) wb_read(8'h14, lat[k]);
        check("lat_b_e3", lat[0], 32'd0);
        check("lat_b_e5", lat[1], 32'd1);
        check("lat_b_e7", lat[2], 32'd1);
        wb_write(8'h10, 32'd0);
        wb_read(8'h14, q);
        check("ack_clear_2cyc_b", q, 32'd0);
        model_req(20, 16'h0000, 19'h0, 15'h0, etr, etdp, estate);

        // REQ dropped while the computation is in flight still completes it.
        load_operands(5'd20, 16'hC000, 19'h0, 15'h0);
        wb_write(8'h10, 32'd1);
        wb_write(8'h10, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        model_req(20, 16'hC000, 19'h0, 15'h0, etr, etdp, estate);
        wb_read(8'h1C, q);
        check("early_drop_tdp", q, {31'd0, etdp});
        wb_read(8'h20, q);
        check("early_drop_state", q, estate);
        wb_read(8'h14, q);
        check("early_drop_ack", q, 32'd0);

        for (int n = 0; n < 150; n++) begin
            ch = 5'($urandom_range(31, 0));
            case ($urandom_range(3, 0))
                0: a = 16'($urandom_range(16'hD202, 16'hD1FE));
                1: a = 16'($urandom_range(16'hFFFF, 16'h8000));
                default: a = 16'($urandom);
            endcase
            y = {4'($urandom_range(15, 0)), 15'($urandom)};
            if ($urandom_range(1, 0) == 1) begin
                thr = model_dqthr(y);
                mag = thr + $urandom_range(2, 0) - 1;
                if (mag > 16383) mag = 16383;
                d = {1'($urandom), 14'(mag)};
            end else begin
                d = 15'($urandom);
            end
            do_req(ch, a, y, d, rtr, rtdp, rstate);
            model_req(int'(ch), a, y, d, etr, etdp, estate);
            check($sformatf("rand%0d_tr", n), {31'd0, rtr}, {31'd0, etr});
            check($sformatf("rand%0d_tdp", n), {31'd0, rtdp}, {31'd0, etdp});
            check($sformatf("rand%0d_state", n), rstate, estate);
        end

        // Reset asserted while the FSM sits in CALC2.
        load_operands(5'd9, 16'hC000, 19'h0, 15'h0);
        wb_write(8'h10, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #3;
        check("midreset_wb_ack", {31'd0, ack}, 32'd0);
        check("midreset_wb_dat", rdat, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) model_td[i] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        for (int r = 0; r < 9; r++) begin
            wb_read(8'(r * 4), q);
            check($sformatf("midreset_reg%0h", r * 4), q, 32'd0);
            check("wb_err", {31'd0, err}, 32'd0);
        end
        do_req(5'd9, 16'hC000, 19'h0, 15'h0, rtr, rtdp, rstate);
        model_req(9, 16'hC000, 19'h0, 15'h0, etr, etdp, estate);
        check("post_reset_tdp", {31'd0, rtdp}, {31'd0, etdp});
        check("post_reset_state", rstate, estate);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
